// File: rtl/sqrt_request_scheduler_pkg.sv
// sqrt_sched_pkg: shared state encoding and default sizes for the sqrt request scheduler.
package sqrt_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, RESPOND} sched_state_t;
  localparam int DEF_WORD_LENGTH  = 16;
  localparam int DEF_NUM_REQ      = 2;
  localparam int DEF_SQRT_LATENCY = 10;
endpackage

// File: rtl/sqrt_request_scheduler_if.sv
// sqrt_request_scheduler_if: requester handshake plus datapath connection of the sqrt scheduler.
interface sqrt_request_scheduler_if import sqrt_sched_pkg::*; #(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int NUM_REQ     = DEF_NUM_REQ
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_operand;
  logic [NUM_REQ-1:0]             req_ack;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [WORD_LENGTH-1:0]         resp_result;
  logic [WORD_LENGTH-1:0]         resp_residue;
  logic                           sqrt_start;
  logic [WORD_LENGTH-1:0]         sqrt_data;
  logic [WORD_LENGTH-1:0]         sqrt_result;
  logic [WORD_LENGTH-1:0]         sqrt_residue;
  modport master (
    input  req, req_operand, resp_ready, sqrt_result, sqrt_residue,
    output req_ack, resp_valid, resp_result, resp_residue, sqrt_start, sqrt_data
  );
  modport slave (
    output req, req_operand, resp_ready, sqrt_result, sqrt_residue,
    input  req_ack, resp_valid, resp_result, resp_residue, sqrt_start, sqrt_data
  );
endinterface

// File: rtl/sqrt_request_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      grant_o,
  output logic               any_o
);
  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    grant_o = '0;
    any_o   = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % NUM_REQ]) grant_o = IW'((int'(ptr_i) + k) % NUM_REQ);
  end
endmodule

// File: rtl/sqrt_request_scheduler.sv
// sqrt_request_scheduler: round-robin job sequencer sharing one iterative sqrt datapath.
module sqrt_request_scheduler import sqrt_sched_pkg::*; #(
  parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int SQRT_LATENCY = DEF_SQRT_LATENCY
) (
  input  logic                    clk,
  input  logic                    reset,
  sqrt_request_scheduler_if.master bus,
  output logic                    busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(SQRT_LATENCY) + 1;
  sched_state_t           state_q, state_d;
  logic [IW-1:0]          grant_q, ptr_q, arb_grant;
  logic                   arb_any;
  logic [CW-1:0]          cnt_q;
  logic [WORD_LENGTH-1:0] data_q, result_q, residue_q;
  logic [NUM_REQ-1:0]     grant_oh;
  logic                   accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .grant_o(arb_grant),
    .any_o  (arb_any)
  );

  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign accept   = bus.resp_ready[grant_q];

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb_any ? LOAD : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = (cnt_q == '0) ? CAPTURE : RUN;
      CAPTURE: state_d = RESPOND;
      RESPOND: state_d = accept ? IDLE : RESPOND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ack      = (state_q == LOAD) ? grant_oh : '0;
    bus.resp_valid   = (state_q == RESPOND) ? grant_oh : '0;
    bus.sqrt_start   = state_q == LOAD;
    bus.sqrt_data    = data_q;
    bus.resp_result  = result_q;
    bus.resp_residue = residue_q;
    busy             = state_q != IDLE;
  end

  // RUN holds for SQRT_LATENCY cycles: counter loads latency-1 and exits on zero.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      result_q  <= '0;
      residue_q <= '0;
    end else begin
      if (state_q == IDLE && arb_any) begin
        grant_q <= arb_grant;
        data_q  <= bus.req_operand[arb_grant*WORD_LENGTH +: WORD_LENGTH];
      end
      cnt_q <= (state_q == LOAD) ? CW'(SQRT_LATENCY - 1) :
               (state_q == RUN && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      if (state_q == CAPTURE) begin
        result_q  <= bus.sqrt_result;
        residue_q <= bus.sqrt_residue;
      end
      if (state_q == RESPOND && accept)
        ptr_q <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
endmodule

// File: tb/tb_sqrt_request_scheduler.sv
// tb_sqrt_request_scheduler: job-level reference model with per-cycle compare plus directed jobs.
module tb_sqrt_request_scheduler;
  import sqrt_sched_pkg::*;
  localparam int WL = 16, N = 2, LAT = 10, RSP = LAT + 2;

  logic clk = 0, reset = 0, busy;
  logic [WL-1:0] ops [N];
  int checks = 0, errors = 0;

  sqrt_request_scheduler_if #(.WORD_LENGTH(WL), .NUM_REQ(N)) bus();
  sqrt_request_scheduler #(.WORD_LENGTH(WL), .NUM_REQ(N), .SQRT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always_comb for (int i = 0; i < N; i++) bus.req_operand[i*WL +: WL] = ops[i];

  // Datapath stand-in: garbage until LAT cycles after it sees the start pulse.
  int dp_cnt = 0;
  logic [WL-1:0] dp_op = '0;
  always @(posedge clk)
    if (bus.sqrt_start) begin dp_op <= bus.sqrt_data; dp_cnt <= LAT; end
    else if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
  assign bus.sqrt_result  = (dp_cnt == 0) ? WL'(isqrt(int'(dp_op))) : 16'hBEEF;
  assign bus.sqrt_residue = (dp_cnt == 0) ? WL'(int'(dp_op) - isqrt(int'(dp_op)) ** 2) : 16'hDEAD;

  // Job model: m_t counts cycles since the grant; response appears at t == LAT+2.
  bit m_busy = 0;
  int m_t = 0, m_g = 0, m_ptr = 0, m_op = 0, m_res = 0, m_rsd = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_t = 0; m_g = 0; m_ptr = 0; m_op = 0; m_res = 0; m_rsd = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N && !m_busy; k++)
        if (bus.req[(m_ptr + k) % N]) begin m_g = (m_ptr + k) % N; m_busy = 1; end
      if (m_busy) begin m_op = int'(ops[m_g]); m_t = 0; end
    end else if (m_t < RSP) begin
      m_t++;
      if (m_t == RSP) begin m_res = isqrt(m_op); m_rsd = m_op - m_res * m_res; end
    end else if (bus.resp_ready[m_g]) begin
      m_busy = 0; m_ptr = (m_g + 1) % N;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] oh;
    oh = N'(1) << m_g;
    chk("req_ack", 32'(bus.req_ack), (m_busy && m_t == 0) ? 32'(oh) : 0);
    chk("resp_valid", 32'(bus.resp_valid), (m_busy && m_t == RSP) ? 32'(oh) : 0);
    chk("sqrt_start", 32'(bus.sqrt_start), 32'(m_busy && m_t == 0));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("resp_result", 32'(bus.resp_result), m_res);
    chk("resp_residue", 32'(bus.resp_residue), m_rsd);
    if (m_busy && m_t <= RSP - 1) chk("sqrt_data", 32'(bus.sqrt_data), m_op);
  end

  task automatic wait_resp(input int idx, output int n, output int starts, output int cap);
    n = 0; starts = 0; cap = -1;
    while (!bus.resp_valid[idx] && n < 40) begin
      @(posedge clk); #1;
      n++;
      bus.req = bus.req & ~bus.req_ack;
      if (bus.sqrt_start) starts++;
      if (n == RSP) cap = int'(bus.sqrt_data);
    end
  endtask

  task automatic accept(input int idx, input int stall);
    logic [WL-1:0] r0;
    r0 = bus.resp_result;
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus.resp_valid[idx]), 1);
      chk("stall_result", 32'(bus.resp_result), 32'(r0));
      chk("stall_busy", 32'(busy), 1);
      chk("stall_no_grant", 32'(bus.req_ack), 0);
    end
    bus.resp_ready[idx] = 1;
    @(posedge clk); #1;
    bus.resp_ready[idx] = 0;
    chk("accepted", 32'(bus.resp_valid), 0);
  endtask

  task automatic job(input int idx, input logic [WL-1:0] op, input int er, input int es, input int stall);
    int n, st, cd;
    ops[idx] = op;
    bus.req[idx] = 1;
    wait_resp(idx, n, st, cd);
    chk("latency", n, 13);
    chk("start_cycles", st, 1);
    chk("capture_data", cd, 32'(op));
    chk("result", 32'(bus.resp_result), er);
    chk("residue", 32'(bus.resp_residue), es);
    accept(idx, stall);
  endtask

  task automatic pair(input int a, input int ar, input int as_, input int b, input int br, input int bs);
    int n, st, cd;
    ops[0] = 81; ops[1] = 50;
    bus.req = 2'b11;
    wait_resp(a, n, st, cd);
    chk("pair_first_latency", n, 13);
    chk("pair_first_result", 32'(bus.resp_result), ar);
    chk("pair_first_residue", 32'(bus.resp_residue), as_);
    accept(a, 0);
    wait_resp(b, n, st, cd);
    chk("pair_second_latency", n, 13);
    chk("pair_second_result", 32'(bus.resp_result), br);
    chk("pair_second_residue", 32'(bus.resp_residue), bs);
    accept(b, 0);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_ack"}, 32'(bus.req_ack), 0);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_start"}, 32'(bus.sqrt_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_data"}, 32'(bus.sqrt_data), 0);
    chk({tag, "_result"}, 32'(bus.resp_result), 0);
    chk({tag, "_residue"}, 32'(bus.resp_residue), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n, st, cd, side;
    bus.req = '0; bus.resp_ready = '0; ops[0] = '0; ops[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset_outputs_zero("por");
    reset = 1;
    @(posedge clk); #1;
    pair(0, 9, 0, 1, 7, 1);
    job(0, 144, 12, 0, 0);
    job(0, 200, 14, 4, 5);
    pair(1, 7, 1, 0, 9, 0);
    ops[0] = 144; bus.req[0] = 1; n = 0; side = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.req_ack[0] && n < 40);
    chk("drop_ack0_seen", 32'(bus.req_ack[0]), 1);
    bus.req[0] = 0;
    ops[1] = 49; bus.req[1] = 1;
    repeat (2) begin @(posedge clk); #1; side += int'(bus.req_ack[1] | bus.resp_valid[1]); end
    bus.req[1] = 0;
    wait_resp(0, n, st, cd);
    chk("drop_result", 32'(bus.resp_result), 12);
    accept(0, 0);
    repeat (3) begin @(posedge clk); #1; side += int'(bus.req_ack[1] | bus.resp_valid[1]); end
    chk("drop_no_service", side, 0);
    chk("drop_idle", 32'(busy), 0);
    ops[0] = 200; bus.req[0] = 1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.req_ack[0] && n < 40);
    bus.req[0] = 0;
    repeat (4) @(posedge clk);
    #1 reset = 0;
    #1 reset_outputs_zero("mid_reset");
    @(posedge clk); #1 reset = 1;
    job(1, 49, 7, 0, 0);
    pair(0, 9, 0, 1, 7, 1);
    repeat (3) @(posedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
